decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: datawidth, default 32, register and data word width.
REQ-002 Parameter: regcount, default 32, number of architectural registers; address width is log2(regcount).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: instruction  input  32  word from the fetch stage.
REQ-006 Port: in_valid  input  1  instruction is valid this cycle.
REQ-007 Port: stall  input  1  hold the IF/ID register contents.
REQ-008 Port: flush  input  1  replace the IF/ID register with NOP.
REQ-009 Port: wb_en, wb_addr, wb_data  input  1/5/datawidth  register-file write-back.
REQ-010 Port: rs1_data, rs2_data  output  datawidth each  operand values.
REQ-011 Port: imm  output  datawidth  sign-extended immediate.
REQ-012 Port: rd, alu_op  output  5/4  destination register and ALU operation code.
REQ-013 Port: reg_write, mem_read, mem_write, illegal  output  1 each  control flags.
REQ-014 Port: out_valid  output  1  decoded outputs valid.
REQ-015 Port: branch, branch_offset  output  1/32  taken-branch request and offset in half-words, to fetch.

Function
REQ-016 IF/ID register: on rising edge, flush loads NOP (0x00000013) and valid=0; else stall holds; else loads instruction and in_valid.
REQ-017 Priority at a single edge: rst > flush > stall > load.
REQ-018 All decode outputs are combinational from the IF/ID register; latency = 1 cycle from instruction input to outputs.
REQ-019 out_valid equals the registered valid bit.
REQ-020 Supported opcodes: R-type, I-type ALU, LOAD, STORE, BRANCH, LUI, JAL; any other opcode sets illegal=1 and forces reg_write, mem_read, mem_write and branch to 0.
REQ-021 imm: I, S, B, U and J formats sign-extended to datawidth; B format keeps bit 0 = 0.
REQ-022 alu_op: R-type = {funct7[5], funct3}; I-type ALU = {funct7[5] only for funct3=101, else 0, funct3}; LOAD/STORE/JAL/LUI = 4'b0000 (ADD).
REQ-023 Register-file reads are combinational; register x0 always reads 0, and writes to x0 are ignored.
REQ-024 Write-back is committed on rising edge when wb_en=1.
REQ-025 Same-cycle bypass: when wb_en=1 and wb_addr equals a nonzero read address, the read returns wb_data.
REQ-026 branch=1 only when out_valid=1, opcode is BRANCH and the condition (BEQ/BNE/BLT/BGE/BLTU/BGEU on bypassed operands) is true, or the opcode is JAL.
REQ-027 branch_offset = imm >> 1 arithmetic; 0 whenever branch=0.
REQ-028 Control flags reg_write, mem_read, mem_write and branch are all 0 whenever out_valid=0.

Reset
REQ-029 While rst=1 at a rising edge: all registers are cleared to 0, the IF/ID register is loaded with NOP, and valid=0.
REQ-030 Reset mid-stall or mid-flush discards the held instruction; outputs are all 0 (imm=0, rd=0) on the cycle after reset.

Structure
REQ-031 Shared package holds opcode constants, the NOP constant, the alu_op encodings and the instruction-format field positions.
REQ-032 The register file is a separate sub-module, regfile, with 2 combinational read ports, 1 write port and bypass; decode instantiates it once.

Verification
REQ-033 Reset, then in_valid=1 with instruction 0x00500093 (addi x1,x0,5) -> next cycle: out_valid=1, rd=1, imm=5, reg_write=1, alu_op=0.
REQ-034 wb_en=1, wb_addr=1, wb_data=0x1234 in the same cycle the IF/ID register holds add x2,x1,x1 -> rs1_data=rs2_data=0x1234.
REQ-035 x1=x2=7, decode beq x1,x2,+16 -> branch=1, branch_offset=8; with x2=8 -> branch=0, branch_offset=0.
REQ-036 Write wb_addr=0, wb_data=0xFFFFFFFF, then read x0 -> rs1_data=0.
REQ-037 Assert stall for 3 cycles while the instruction input changes -> outputs unchanged; flush -> out_valid=0 and all control flags 0 on the next cycle.
REQ-038 Load opcode 0x7F, then rst asserted mid-stall -> illegal=1 with control flags 0; after reset, registers read 0 and out_valid=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, NOP, ALU codes, instruction field positions
// and immediate extraction helpers.
package decode_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_t;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [3:0]  ALU_ADD = 4'b0000;
  localparam logic [2:0]  F3_SR   = 3'b101;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: two combinational read ports with write-back bypass, one write
// port, x0 hard-wired to zero.
module regfile
  import decode_pkg::*;
#(
  parameter int unsigned datawidth = 32,
  parameter int unsigned regcount  = 32,
  localparam int unsigned AW = $clog2(regcount)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        i_raddr1,
  input  logic [AW-1:0]        i_raddr2,
  output logic [datawidth-1:0] o_rdata1,
  output logic [datawidth-1:0] o_rdata2,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [datawidth-1:0] i_wdata
);

  logic [datawidth-1:0] r_regs [regcount];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < regcount; i++) r_regs[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != '0) o_rdata1 = (i_we && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
    if (i_raddr2 != '0) o_rdata2 = (i_we && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
  end

endmodule

// File: rtl/decode.sv
// Decode stage: IF/ID pipeline register, instruction decode, register-file read
// and branch resolution toward fetch.
module decode
  import decode_pkg::*;
#(
  parameter int unsigned datawidth = 32,
  parameter int unsigned regcount  = 32,
  localparam int unsigned AW = $clog2(regcount)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [datawidth-1:0] wb_data,
  output logic [datawidth-1:0] rs1_data,
  output logic [datawidth-1:0] rs2_data,
  output logic [datawidth-1:0] imm,
  output logic [4:0]           rd,
  output logic [3:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 illegal,
  output logic                 out_valid,
  output logic                 branch,
  output logic [31:0]          branch_offset
);

  logic [31:0] r_instr;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_instr <= instruction;
      r_valid <= in_valid;
    end
  end

  opcode_t    w_opc;
  logic [2:0] w_f3;
  logic       w_f7b5;
  assign w_opc  = opcode_t'(r_instr[OPC_LSB +: 7]);
  assign w_f3   = r_instr[F3_LSB +: 3];
  assign w_f7b5 = r_instr[F7_LSB + 5];

  logic [31:0] w_imm32;
  logic [3:0]  w_alu_op;
  logic        w_wr, w_mrd, w_mwr, w_is_br, w_is_jal, w_illegal;

  always_comb begin
    w_imm32   = '0;
    w_alu_op  = ALU_ADD;
    w_wr      = 1'b0;
    w_mrd     = 1'b0;
    w_mwr     = 1'b0;
    w_is_br   = 1'b0;
    w_is_jal  = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_OP:     begin w_alu_op = {w_f7b5, w_f3}; w_wr = 1'b1; end
      OPC_OPIMM:  begin
        w_imm32  = imm_i(r_instr);
        // funct7[5] only selects SRA vs SRL; elsewhere those bits are immediate
        w_alu_op = {(w_f3 == F3_SR) & w_f7b5, w_f3};
        w_wr     = 1'b1;
      end
      OPC_LOAD:   begin w_imm32 = imm_i(r_instr); w_wr = 1'b1; w_mrd = 1'b1; end
      OPC_STORE:  begin w_imm32 = imm_s(r_instr); w_mwr = 1'b1; end
      OPC_BRANCH: begin w_imm32 = imm_b(r_instr); w_is_br = 1'b1; end
      OPC_LUI:    begin w_imm32 = imm_u(r_instr); w_wr = 1'b1; end
      OPC_JAL:    begin w_imm32 = imm_j(r_instr); w_wr = 1'b1; w_is_jal = 1'b1; end
      default:    w_illegal = 1'b1;
    endcase
  end

  logic [datawidth-1:0] w_rs1, w_rs2;

  regfile #(.datawidth(datawidth), .regcount(regcount)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (AW'(r_instr[RS1_LSB +: 5])),
    .i_raddr2 (AW'(r_instr[RS2_LSB +: 5])),
    .o_rdata1 (w_rs1),
    .o_rdata2 (w_rs2),
    .i_we     (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data)
  );

  logic w_taken;
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      F3_BEQ:  w_taken = (w_rs1 == w_rs2);
      F3_BNE:  w_taken = (w_rs1 != w_rs2);
      F3_BLT:  w_taken = ($signed(w_rs1) <  $signed(w_rs2));
      F3_BGE:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
      F3_BLTU: w_taken = (w_rs1 <  w_rs2);
      F3_BGEU: w_taken = (w_rs1 >= w_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  assign rs1_data      = w_rs1;
  assign rs2_data      = w_rs2;
  assign imm           = datawidth'($signed(w_imm32));
  assign rd            = r_instr[RD_LSB +: 5];
  assign alu_op        = w_alu_op;
  assign illegal       = w_illegal;
  assign out_valid     = r_valid;
  assign reg_write     = r_valid & w_wr;
  assign mem_read      = r_valid & w_mrd;
  assign mem_write     = r_valid & w_mwr;
  assign branch        = r_valid & ((w_is_br & w_taken) | w_is_jal);
  assign branch_offset = branch ? $unsigned($signed(w_imm32) >>> 1) : '0;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode with hand-computed expectations.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, wb_en;
  logic [31:0] instruction, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] rs1_data, rs2_data, imm, branch_offset;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        reg_write, mem_read, mem_write, illegal, out_valid, branch;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode #(.datawidth(32), .regcount(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal),
    .out_valid(out_valid), .branch(branch), .branch_offset(branch_offset)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp_rmwb);
    chk({tag, ".reg_write"}, 32'(reg_write), 32'(exp_rmwb[3]));
    chk({tag, ".mem_read"},  32'(mem_read),  32'(exp_rmwb[2]));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(exp_rmwb[1]));
    chk({tag, ".branch"},    32'(branch),    32'(exp_rmwb[0]));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; instruction = 32'h0000_0000;
    tick(); tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.imm", imm, 32'd0);
    chk("rst.rd", 32'(rd), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk_flags("rst", 4'b0000);
    rst = 1'b0;

    // addi x1,x0,5
    instruction = 32'h0050_0093; in_valid = 1'b1;
    tick();
    chk("addi.out_valid", 32'(out_valid), 32'd1);
    chk("addi.rd", 32'(rd), 32'd1);
    chk("addi.imm", imm, 32'd5);
    chk("addi.alu_op", 32'(alu_op), 32'd0);
    chk_flags("addi", 4'b1000);

    // addi x1,x0,-1 : negative I immediate
    instruction = 32'hFFF0_0093;
    tick();
    chk("addi_neg.imm", imm, 32'hFFFF_FFFF);

    // srai x1,x1,3 : alu_op carries funct7[5]
    instruction = 32'h4030_D093;
    tick();
    chk("srai.alu_op", 32'(alu_op), 32'hD);
    chk("srai.imm", imm, 32'h0000_0403);

    // sub x3,x1,x2
    instruction = 32'h4020_81B3;
    tick();
    chk("sub.alu_op", 32'(alu_op), 32'h8);
    chk("sub.rd", 32'(rd), 32'd3);

    // add x2,x1,x1 with same-cycle write-back of x1
    instruction = 32'h0010_8133;
    tick();
    chk("add.rs1_before", rs1_data, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
    #1;
    chk("bypass.rs1", rs1_data, 32'h1234);
    chk("bypass.rs2", rs2_data, 32'h1234);
    tick();
    wb_en = 1'b0;
    #1;
    chk("commit.rs1", rs1_data, 32'h1234);
    chk("commit.rs2", rs2_data, 32'h1234);

    // x1 = x2 = 7, then beq x1,x2,+16
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    tick();
    wb_addr = 5'd2;
    tick();
    wb_en = 1'b0;
    instruction = 32'h0020_8863;
    tick();
    chk("beq.imm", imm, 32'd16);
    chk("beq_eq.branch", 32'(branch), 32'd1);
    chk("beq_eq.offset", branch_offset, 32'd8);
    chk_flags("beq_eq", 4'b0001);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd8;
    #1;
    chk("beq_ne_bypass.branch", 32'(branch), 32'd0);
    chk("beq_ne_bypass.offset", branch_offset, 32'd0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("beq_ne.branch", 32'(branch), 32'd0);

    // jal x1,-4
    instruction = 32'hFFDF_F0EF;
    tick();
    chk("jal.imm", imm, 32'hFFFF_FFFC);
    chk("jal.offset", branch_offset, 32'hFFFF_FFFE);
    chk_flags("jal", 4'b1001);

    // sw x2,8(x1)
    instruction = 32'h0020_A423;
    tick();
    chk("sw.imm", imm, 32'd8);
    chk_flags("sw", 4'b0010);

    // lw x5,-8(x1)
    instruction = 32'hFF80_A283;
    tick();
    chk("lw.imm", imm, 32'hFFFF_FFF8);
    chk_flags("lw", 4'b1100);

    // lui x5,0x12345
    instruction = 32'h1234_52B7;
    tick();
    chk("lui.imm", imm, 32'h1234_5000);
    chk("lui.rd", 32'(rd), 32'd5);
    chk_flags("lui", 4'b1000);

    // writes to x0 are ignored, including the bypass path
    instruction = 32'h0050_0093;
    tick();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_bypass.rs1", rs1_data, 32'd0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("x0_commit.rs1", rs1_data, 32'd0);

    // stall holds for three cycles while the input changes
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instruction = 32'h0020_A423 + 32'(i << 7);
      in_valid = 1'b0;
      tick();
      chk("stall.rd", 32'(rd), 32'd1);
      chk("stall.imm", imm, 32'd5);
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk_flags("stall", 4'b1000);
    end
    stall = 1'b0; flush = 1'b1; in_valid = 1'b1;
    tick();
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.imm", imm, 32'd0);
    chk_flags("flush", 4'b0000);

    // flush wins over stall
    flush = 1'b0;
    instruction = 32'hFFDF_F0EF;
    tick();
    chk("jal2.branch", 32'(branch), 32'd1);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_stall.out_valid", 32'(out_valid), 32'd0);
    chk_flags("flush_stall", 4'b0000);
    stall = 1'b0; flush = 1'b0;

    // illegal opcode, then reset during stall
    instruction = 32'h0000_007F;
    tick();
    chk("illegal.illegal", 32'(illegal), 32'd1);
    chk("illegal.out_valid", 32'(out_valid), 32'd1);
    chk("illegal.imm", imm, 32'd0);
    chk_flags("illegal", 4'b0000);
    stall = 1'b1; instruction = 32'h0050_0093;
    tick();
    chk("illegal_stall.illegal", 32'(illegal), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    chk("post_rst.illegal", 32'(illegal), 32'd0);
    chk("post_rst.out_valid", 32'(out_valid), 32'd0);
    chk("post_rst.imm", imm, 32'd0);
    chk("post_rst.rd", 32'(rd), 32'd0);
    chk_flags("post_rst", 4'b0000);

    // registers cleared by reset: x1 was 7, x2 was 8
    instruction = 32'h0010_8133; in_valid = 1'b0;
    tick();
    chk("cleared.rs1", rs1_data, 32'd0);
    chk("cleared.rs2", rs2_data, 32'd0);
    chk("cleared.out_valid", 32'(out_valid), 32'd0);
    chk_flags("cleared", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
